// File: rtl/axis_pkg.sv
// Shared types and helpers for the packet arbiter and its output register slice.
package axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int unsigned SKID_DEPTH = 2;

    // First requester at or after ptr, searching circularly over ns ports.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int ns);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(ptr) + i) % ns;
            if (i < ns && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid.sv
// Two-entry register slice: registered outputs, upstream ready taken from the entry count only.
module axis_skid
    import axis_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_last_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_last_o
);

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic          main_last_q, main_last_d, skid_last_q, skid_last_d;
    logic          m_valid_q;
    logic          push, pop;

    assign s_ready_o = (count_q < 2'(SKID_DEPTH));
    assign push      = s_valid_i && s_ready_o;
    assign pop       = m_valid_q && m_ready_i;

    always_comb begin
        count_d     = count_q;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        case (count_q)
            2'd0: if (push) begin
                main_data_d = s_data_i;
                main_last_d = s_last_i;
                count_d     = 2'd1;
            end
            2'd1: if (push && pop) begin
                main_data_d = s_data_i;
                main_last_d = s_last_i;
            end else if (push) begin
                skid_data_d = s_data_i;
                skid_last_d = s_last_i;
                count_d     = 2'd2;
            end else if (pop) begin
                count_d = 2'd0;
            end
            default: if (pop) begin
                // The parked beat moves forward; upstream is held off while full.
                main_data_d = skid_data_q;
                main_last_d = skid_last_q;
                count_d     = 2'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            m_valid_q   <= (count_d != 2'd0);
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = main_data_q;
    assign m_last_o  = main_last_q;

endmodule

// File: rtl/axis_pkt_arb.sv
// Packet-granular round-robin arbiter with length limit and per-grant packet quota.
module axis_pkt_arb
    import axis_pkg::*;
#(
    parameter int NS = 4,
    parameter int DW = 8,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NS*DW-1:0] s_tdata,
    input  logic [NS-1:0]   s_tvalid,
    input  logic [NS-1:0]   s_tlast,
    output logic [NS-1:0]   s_tready,
    input  logic [2*DW-1:0] packet_config,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tvalid,
    output logic            m_tlast,
    input  logic            m_tready,
    output logic [NS-1:0]   gnt,
    output logic            trunc
);

    state_t        state_q, state_d;
    logic [IW-1:0] g_q, g_d, rr_q, rr_d, pick, rr_next;
    logic [NS-1:0] gnt_q, gnt_d;
    logic [DW-1:0] len_q, len_d, kq_q, kq_d, beat_q, beat_d, pkt_q, pkt_d;
    logic          bnd_q, bnd_d;
    logic [DW-1:0] cfg_len, cfg_k, sel_data;
    logic [DW-1:0] src_data [NS];
    logic          sel_valid, sel_last, xfer, skid_rdy, accept, force_last, pkt_end, quota_left;

    assign cfg_len = packet_config[2*DW-1:DW];
    assign cfg_k   = packet_config[DW-1:0];
    assign xfer    = (state_q == XFER);

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_src
            assign src_data[gi] = s_tdata[gi*DW +: DW];
            assign s_tready[gi] = xfer && skid_rdy && (g_q == IW'(gi));
        end
    endgenerate

    assign sel_data   = src_data[g_q];
    assign sel_valid  = s_tvalid[g_q];
    assign sel_last   = s_tlast[g_q];
    assign accept     = xfer && sel_valid && skid_rdy;
    assign force_last = accept && (len_q != '0) && (beat_q == len_q - DW'(1)) && !sel_last;
    assign pkt_end    = accept && (sel_last || force_last);
    assign quota_left = ({1'b0, pkt_q} + {{DW{1'b0}}, 1'b1}) < {1'b0, kq_q};
    assign pick       = IW'(rr_pick(8'(s_tvalid), 3'(rr_q), NS));
    assign rr_next    = (g_q == IW'(NS-1)) ? '0 : g_q + IW'(1);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        len_d   = len_q;
        kq_d    = kq_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        bnd_d   = bnd_q;
        case (state_q)
            IDLE: if (|s_tvalid) begin
                g_d         = pick;
                gnt_d       = '0;
                gnt_d[pick] = 1'b1;
                len_d       = cfg_len;
                kq_d        = (cfg_k == '0) ? DW'(1) : cfg_k;
                beat_d      = '0;
                pkt_d       = '0;
                bnd_d       = 1'b0;
                state_d     = XFER;
            end
            default: begin
                // bnd_q marks the cycle after a packet end where quota continuation is decided.
                if (bnd_q && !sel_valid) begin
                    rr_d    = rr_next;
                    gnt_d   = '0;
                    bnd_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    bnd_d = 1'b0;
                    if (pkt_end) begin
                        beat_d = '0;
                        pkt_d  = pkt_q + DW'(1);
                        if (quota_left) begin
                            bnd_d = 1'b1;
                        end else begin
                            rr_d    = rr_next;
                            gnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else if (accept && !(len_q == '0 && beat_q == '1)) begin
                        beat_d = beat_q + DW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            kq_q    <= '0;
            beat_q  <= '0;
            pkt_q   <= '0;
            bnd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            kq_q    <= kq_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            bnd_q   <= bnd_d;
        end
    end

    axis_skid #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (accept),
        .s_ready_o (skid_rdy),
        .s_data_i  (sel_data),
        .s_last_i  (sel_last || force_last),
        .m_valid_o (m_tvalid),
        .m_ready_i (m_tready),
        .m_data_o  (m_tdata),
        .m_last_o  (m_tlast)
    );

    assign gnt   = gnt_q;
    assign trunc = force_last;

endmodule

// File: tb/tb_axis_pkt_arb.sv
// Scoreboard bench for axis_pkt_arb: per-source driver queues, expected-beat queue, output monitor.
module tb_axis_pkt_arb;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid, s_tlast, s_tready;
    logic [2*DW-1:0]  packet_config;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid, m_tlast, m_tready;
    logic [NS-1:0]    gnt;
    logic             trunc;

    always #5 clk = ~clk;

    axis_pkt_arb #(.NS(NS), .DW(DW), .IW(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .packet_config (packet_config),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .gnt           (gnt),
        .trunc         (trunc)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          seen = 0;
    int          trunc_cnt = 0;
    logic [8:0]  srcq [NS][$];
    logic [8:0]  expq [$];
    logic [NS-1:0] acc;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NS; i++) s += srcq[i].size();
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(expq.size() == 0 && pending() == 0 && gnt == '0 && !m_tvalid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 400), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Source drivers: hold each head beat until the DUT accepts it.
    initial begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        forever begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            @(posedge clk);
            #3;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*DW +: DW]  = srcq[i][0][7:0];
                    s_tlast[i]           = srcq[i][0][8];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard compare plus stall-stability check.
    initial begin
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (trunc) trunc_cnt++;
                if (prev_stall)
                    chk("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, prev_last, prev_data}));
                if (m_tvalid && m_tready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h last %0b, required no beat", m_tdata, m_tlast);
                    end else begin
                        e = expq.pop_front();
                        chk("beat", 32'({m_tlast, m_tdata}), 32'(e));
                    end
                    seen++;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int c0, c1, n, seen0;
        int ord [4];
        logic [8:0] b9;
        logic [3:0] rdy_pat;
        rst_n         = 1'b0;
        m_tready      = 1'b1;
        packet_config = {8'd0, 8'd1};
        repeat (3) tick();
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_outs", 32'({m_tvalid, m_tlast, m_tdata}), 32'd0);
        chk("rst_gnt_trunc", 32'({gnt, trunc}), 32'd0);
        rst_n = 1'b1;

        // 1: single source 0, 4 beats, check latency and grant
        tick();
        for (int b = 0; b < 4; b++) begin
            b9 = {(b == 3), 8'(8'h10 + b)};
            srcq[0].push_back(b9);
            expq.push_back(b9);
        end
        #3;
        chk("t1_s_tvalid", 32'(s_tvalid), 32'h1);
        c0 = cyc;
        n  = 0;
        while (!m_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        c1 = cyc;
        chk("t1_latency", 32'(c1 - c0), 32'd2);
        chk("t1_gnt", 32'(gnt), 32'h1);
        drain("t1_drain");

        // 2: all four sources, two 2-beat packets each, k=1; rr_ptr starts at 1
        tick();
        ord = '{1, 2, 3, 0};
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    srcq[s].push_back({(b == 1), 8'(s*16 + p*2 + b)});
        for (int p = 0; p < 2; p++)
            for (int j = 0; j < 4; j++)
                for (int b = 0; b < 2; b++)
                    expq.push_back({(b == 1), 8'(ord[j]*16 + p*2 + b)});
        drain("t2_drain");

        // 3: k=3, sources 1 and 2 with three 2-beat packets each; rr_ptr=1
        tick();
        packet_config = {8'd0, 8'd3};
        for (int s = 1; s <= 2; s++)
            for (int p = 0; p < 3; p++)
                for (int b = 0; b < 2; b++) begin
                    b9 = {(b == 1), 8'(8'h80 + s*16 + p*2 + b)};
                    srcq[s].push_back(b9);
                    expq.push_back(b9);
                end
        drain("t3_drain");
        chk("t3_no_trunc", 32'(trunc_cnt), 32'd0);

        // 4: len=3, 7-beat packet from source 0 -> ends after beats 3, 6, 7
        tick();
        packet_config = {8'd3, 8'd1};
        trunc_cnt = 0;
        for (int b = 0; b < 7; b++) begin
            srcq[0].push_back({(b == 6), 8'(8'h40 + b)});
            expq.push_back({(b == 2 || b == 5 || b == 6), 8'(8'h40 + b)});
        end
        drain("t4_drain");
        chk("t4_trunc_count", 32'(trunc_cnt), 32'd2);

        // 5: downstream stall, then ready pattern 1,0,0,1
        tick();
        packet_config = {8'd0, 8'd1};
        m_tready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            b9 = {(b == 5), 8'(8'h50 + b)};
            srcq[3].push_back(b9);
            expq.push_back(b9);
        end
        repeat (6) @(negedge clk);
        chk("t5_s_tready_full", 32'(s_tready), 32'd0);
        chk("t5_head_held", 32'({m_tvalid, m_tdata}), 32'({1'b1, 8'h50}));
        rdy_pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            tick();
            m_tready = rdy_pat[i];
        end
        tick();
        m_tready = 1'b1;
        drain("t5_drain");

        // 6: complete packet from source 2 (rr_ptr -> 3), then reset mid-packet
        tick();
        srcq[2].push_back({1'b0, 8'h60});
        srcq[2].push_back({1'b1, 8'h61});
        expq.push_back({1'b0, 8'h60});
        expq.push_back({1'b1, 8'h61});
        drain("t6a_drain");
        tick();
        for (int b = 0; b < 5; b++) srcq[2].push_back({(b == 4), 8'(8'h70 + b)});
        expq.push_back({1'b0, 8'h70});
        expq.push_back({1'b0, 8'h71});
        seen0 = seen;
        n = 0;
        while ((seen - seen0) < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_wait_beats", 32'(n < 50), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_outs", 32'({m_tvalid, m_tlast, m_tdata}), 32'd0);
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_s_tready", 32'(s_tready), 32'd0);
        chk("t6_rst_trunc", 32'(trunc), 32'd0);
        srcq[2].delete();
        expq.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        srcq[1].push_back({1'b0, 8'h91});
        srcq[1].push_back({1'b1, 8'h92});
        srcq[3].push_back({1'b0, 8'h93});
        srcq[3].push_back({1'b1, 8'h94});
        expq.push_back({1'b0, 8'h91});
        expq.push_back({1'b1, 8'h92});
        expq.push_back({1'b0, 8'h93});
        expq.push_back({1'b1, 8'h94});
        n = 0;
        while (gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_gnt", 32'(gnt), 32'h2);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
